// File: rtl/conv_pkg.sv
// conv_pkg: constants and state type shared by the K=7 encoder and the Viterbi decoder.
package conv_pkg;
  localparam int K = 7;
  localparam int NUM_STATES = 64;
  localparam int TAIL_LEN = 6;
  localparam logic [6:0] G0_DEF = 7'o171;
  localparam logic [6:0] G1_DEF = 7'o133;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
endpackage

// File: rtl/conv_symbol_gen.sv
// conv_symbol_gen: combinational {bit, sr} -> {g1,g0} code symbol for a K=7 window.
module conv_symbol_gen
  import conv_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEF,
  parameter logic [6:0] G1 = G1_DEF
) (
  input  logic       data,
  input  logic [5:0] sr,
  output logic [1:0] pair
);
  logic [6:0] w;
  // Window laid out so that wi sits at bit (6-i), matching the polynomial bit order.
  assign w = {data, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]};
  assign pair = {^(w & G1), ^(w & G0)};
endmodule

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7: rate-1/2 K=7 convolutional encoder with valid/ready framing and optional zero tail.
module conv_encoder_k7
  import conv_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEF,
  parameter logic [6:0] G1 = G1_DEF,
  parameter bit TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_first,
  output logic       out_last,
  output logic       busy
);
  state_t     state;
  logic [5:0] sr;
  logic [2:0] tail_cnt;
  logic [1:0] sym;
  logic       slot_free, accept, tail_done;
  assign slot_free = !out_valid || out_ready;
  assign in_ready = !rst && slot_free && state != TAIL;
  assign accept = in_valid && in_ready;
  assign tail_done = tail_cnt == 3'(TAIL_LEN - 1);
  assign busy = state != IDLE;
  conv_symbol_gen #(.G0(G0), .G1(G1)) u_sym (
    .data(in_bit && state != TAIL),
    .sr  (sr),
    .pair(sym)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      tail_cnt <= '0;
      out_valid <= 1'b0;
      out_pair <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else if (slot_free) begin
      out_valid <= accept || state == TAIL;
      out_pair <= sym;
      out_first <= accept && state == IDLE;
      out_last <= accept ? in_last && !TAIL_EN : state == TAIL && tail_done;
      if (accept) begin
        // Truncated frames clear the register so the next frame starts from state 0.
        sr <= (in_last && !TAIL_EN) ? '0 : {sr[4:0], in_bit};
        state <= in_last ? (TAIL_EN ? TAIL : IDLE) : DATA;
        tail_cnt <= '0;
      end else if (state == TAIL) begin
        sr <= {sr[4:0], 1'b0};
        tail_cnt <= tail_cnt + 3'd1;
        if (tail_done) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_conv_encoder_k7.sv
// tb_conv_encoder_k7: directed checks of the K=7 encoder with and without tail termination.
module tb_conv_encoder_k7;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_first, out_last, busy;
  logic [1:0] out_pair;
  logic z_in_ready, z_out_valid, z_out_first, z_out_last, z_busy;
  logic [1:0] z_out_pair;
  int n_assert = 0, n_fail = 0;
  // Hand-derived impulse response {g1,g0} and response to frame {1,0,1}.
  logic [1:0] imp [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
  logic [1:0] f3 [9] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};

  conv_encoder_k7 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair),
    .out_first(out_first), .out_last(out_last), .busy(busy)
  );
  conv_encoder_k7 #(.TAIL_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .in_bit(in_bit),
    .in_last(in_last), .out_valid(z_out_valid), .out_ready(out_ready), .out_pair(z_out_pair),
    .out_first(z_out_first), .out_last(z_out_last), .busy(z_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic l);
    in_valid = v;
    in_bit = b;
    in_last = l;
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input string tag, input logic [1:0] p, input logic f, input logic l);
    chk({tag, " valid"}, 8'(out_valid), 8'd1);
    chk({tag, " pair"}, 8'(out_pair), 8'(p));
    chk({tag, " first"}, 8'(out_first), 8'(f));
    chk({tag, " last"}, 8'(out_last), 8'(l));
  endtask

  task automatic impulse(input string tag);
    step(1'b1, 1'b1, 1'b1);
    sym(tag, imp[0], 1'b1, 1'b0);
    for (int k = 1; k < 7; k++) begin
      step(1'b0, 1'b0, 1'b0);
      sym(tag, imp[k], 1'b0, k == 6);
    end
    chk({tag, " busy end"}, 8'(busy), 8'd0);
    step(1'b0, 1'b0, 1'b0);
    chk({tag, " drained"}, 8'(out_valid), 8'd0);
  endtask

  initial begin
    #12;
    chk("reset out_valid", 8'(out_valid), 8'd0);
    chk("reset in_ready", 8'(in_ready), 8'd0);
    chk("reset busy", 8'(busy), 8'd0);
    chk("reset pair", 8'(out_pair), 8'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("idle in_ready", 8'(in_ready), 8'd1);
    impulse("impulse");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, i == 9);
      sym("zero data", 2'b00, i == 0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      chk("zero tail in_ready", 8'(in_ready), 8'd0);
      step(1'b0, 1'b0, 1'b0);
      sym("zero tail", 2'b00, 1'b0, i == 5);
    end
    chk("zero busy end", 8'(busy), 8'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      out_ready = 1'b0;
      #1 chk("bp in_ready", 8'(in_ready), 8'd0);
      step(1'b0, 1'b0, 1'b0);
      sym("bp hold", imp[k], k == 0, k == 6);
      out_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      if (k < 6) sym("bp next", imp[k+1], 1'b0, k == 5);
      else chk("bp drained", 8'(out_valid), 8'd0);
    end
    step(1'b1, 1'b1, 1'b0);
    sym("b2b f1", f3[0], 1'b1, 1'b0);
    chk("b2b data in_ready", 8'(in_ready), 8'd1);
    step(1'b1, 1'b0, 1'b0);
    sym("b2b f1", f3[1], 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    sym("b2b f1", f3[2], 1'b0, 1'b0);
    for (int t = 3; t < 9; t++) begin
      chk("b2b tail in_ready", 8'(in_ready), 8'd0);
      step(1'b0, 1'b0, 1'b0);
      sym("b2b f1 tail", f3[t], 1'b0, t == 8);
    end
    chk("b2b ready again", 8'(in_ready), 8'd1);
    impulse("b2b f2");
    rst = 1'b1;
    #1 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("notail pair0", 8'(z_out_pair), 8'd3);
    chk("notail first0", 8'(z_out_first), 8'd1);
    chk("notail last0", 8'(z_out_last), 8'd0);
    chk("notail in_ready", 8'(z_in_ready), 8'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("notail pair1", 8'(z_out_pair), 8'd2);
    chk("notail first1", 8'(z_out_first), 8'd0);
    chk("notail last1", 8'(z_out_last), 8'd1);
    chk("notail busy", 8'(z_busy), 8'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("notail next pair", 8'(z_out_pair), 8'd3);
    chk("notail next first", 8'(z_out_first), 8'd1);
    chk("notail next last", 8'(z_out_last), 8'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("notail drained", 8'(z_out_valid), 8'd0);
    rst = 1'b1;
    #1 rst = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 4; k++) step(1'b0, 1'b0, 1'b0);
    sym("pre reset", imp[3], 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("midtail rst out_valid", 8'(out_valid), 8'd0);
    chk("midtail rst busy", 8'(busy), 8'd0);
    chk("midtail rst in_ready", 8'(in_ready), 8'd0);
    chk("midtail rst last", 8'(out_last), 8'd0);
    @(negedge clk) rst = 1'b0;
    impulse("after reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/conv_encoder_k7.md
Name: conv_encoder_k7

Overview:
- Rate-1/2, constraint-length-7 convolutional encoder. Transmit-side counterpart of the 64-state Viterbi decoder's branch-metric/ACS datapath.
- Accepts a framed serial bit stream over a valid/ready handshake.
- Emits one 2-bit code symbol per input bit, in the same pair format the decoder's branch-metric units consume.
- Optionally appends K-1 zero tail bits so every frame ends in state 0, the decoder's traceback start state.

Parameters:
- G0, 7'o171, generator polynomial for out_pair[0]; MSB taps the current input bit.
- G1, 7'o133, generator polynomial for out_pair[1]; MSB taps the current input bit.
- TAIL_EN, 1, 1 = append 6 zero tail bits after the in_last bit; 0 = truncated frame, no tail.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_bit/in_last valid
- in_ready  output  1  encoder accepts the input this cycle
- in_bit  input  1  information bit
- in_last  input  1  marks the final information bit of a frame
- out_valid  output  1  out_pair valid
- out_ready  input  1  downstream accepts out_pair
- out_pair  output  2  code symbol {g1,g0}
- out_first  output  1  symbol belongs to the first input bit of a frame
- out_last  output  1  final symbol of a frame (last tail symbol, or last data symbol if TAIL_EN=0)
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; sr=0; tail_cnt=0; out_valid=0; out_pair=0; out_first=0; out_last=0; in_ready=0 while rst is asserted. A reset mid-frame drops the frame; no partial tail is emitted.
- Window: w0 = current input (or 0 in TAIL); w1..w6 = sr[0..5], where sr[0] is the most recent previous bit.
  - g0 = XOR of wi where G0 bit (6-i) = 1.
  - g1 = XOR of wi where G1 bit (6-i) = 1.
  - Default taps: g0 = w0^w1^w2^w3^w6; g1 = w0^w2^w3^w5^w6.
- Output stage: single register. slot_free = !out_valid || out_ready.
- in_ready = slot_free && (state==IDLE || state==DATA).
- Accept (in_valid && in_ready):
  - Register out_pair from {in_bit, sr}; out_valid=1.
  - Shift: sr <= {sr[4:0], in_bit}.
  - Latency: symbol visible the cycle after acceptance. Throughput: 1 symbol/cycle under continuous out_ready.
- IDLE: sr==0.
  - Accept -> out_first=1.
  - If in_last: go to TAIL (TAIL_EN=1), or stay IDLE with out_last=1 (TAIL_EN=0).
  - Otherwise go to DATA.
- DATA: accept with out_first=0.
  - in_last with TAIL_EN=1 -> TAIL, tail_cnt=0.
  - in_last with TAIL_EN=0 -> IDLE, out_last=1, sr cleared to 0.
- TAIL: in_ready=0. Each cycle with slot_free:
  - Emit the symbol for w0=0 and shift a 0 in; tail_cnt++.
  - On tail_cnt==5 (6th tail symbol): out_last=1, go to IDLE. sr is 0 by construction.
- Frame sequencing:
  - A new frame may be accepted in the cycle after the last tail symbol is loaded; no bubble other than IDLE re-entry.
  - in_last in the same cycle as the first bit gives a 1-bit frame.
- Backpressure: while out_valid && !out_ready, out_pair/out_first/out_last hold stable and no state changes.
- Symbol count per frame: N data symbols + 6 tail symbols (TAIL_EN=1), or N symbols (TAIL_EN=0).

Decomposition:
- Shared package conv_pkg:
  - K=7, NUM_STATES=64, TAIL_LEN=6.
  - Default generator constants G0_DEF=7'o171, G1_DEF=7'o133.
  - State enum {IDLE, DATA, TAIL}.
  - The decoder's branch-metric generator reuses the same constants.
- One sub-module: conv_symbol_gen — purely combinational {bit, sr[5:0]} -> {g1,g0}, parameterised by G0/G1. The decoder's expected-symbol tables can reuse it.

Test Plan:
- Impulse: frame {1}, in_last on the first bit, TAIL_EN=1, out_ready=1 -> 7 symbols 11,01,11,11,00,10,11; out_first on #0, out_last on #6; sr ends at 0.
- All-zero 10-bit frame -> 16 symbols, all 00; busy falls the cycle after the last symbol is accepted.
- Backpressure: the impulse frame with out_ready toggling 1010... -> same 7 symbols, in order, with values held while stalled; in_ready=0 whenever out_valid && !out_ready.
- Back-to-back frames {1,0,1} then {1}: in_ready low during the 6-cycle tail, then high.
  - Second frame's first symbol = 11 with out_first=1, proving state was zero-terminated.
- TAIL_EN=0, frame {1,1}: exactly 2 symbols, 11 then 10; out_last on the 2nd; the next frame starts from sr=0.
- Async reset asserted mid-TAIL (tail_cnt=3) -> out_valid=0, busy=0 immediately. After release, frame {1} reproduces the impulse response exactly.
